// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC next-state, IF/ID register, halt sequencer
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  output logic [15:0] pc_next,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        valid_q, valid_d;

  logic [15:0] pc_plus2;
  logic        is_halt;

  // RESET_PC is owned by the external PC register; kept here for a uniform parameter set.
  logic [15:0] unused_reset_pc;
  assign unused_reset_pc = RESET_PC;

  assign pc_plus2  = pc + 16'd2;
  assign is_halt   = (imem_rdata[15:12] == HALT_OPCODE);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (branch_taken)  state_d = RUN;
        else if (stall)    state_d = RUN;
        else if (is_halt)  state_d = HALT_PEND;
      end
      HALT_PEND: if (!stall) state_d = HALTED;
      HALTED:    state_d = HALTED;
      default:   state_d = RUN;
    endcase
  end

  // Branch squashes the fetched word, so a HLT under a taken branch never starts halting.
  always_comb begin
    pc_next    = pc;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          pc_next    = branch_target;
          instr_d    = NOP_INSTR;
          pc_plus2_d = 16'h0000;
          valid_d    = 1'b0;
        end else if (!stall) begin
          pc_next    = is_halt ? pc : pc_plus2;
          instr_d    = imem_rdata;
          pc_plus2_d = pc_plus2;
          valid_d    = 1'b1;
        end
      end
      HALT_PEND: begin
        if (!stall) begin
          instr_d    = NOP_INSTR;
          pc_plus2_d = 16'h0000;
          valid_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign if_id_instr    = instr_q;
  assign if_id_pc_plus2 = pc_plus2_q;
  assign if_id_valid    = valid_q;
  assign halted         = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .pc_next        (pc_next),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc = 16'h0000; imem_rdata = 16'h1234;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    #2;
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %h exp 0", if_id_valid); else pass_cnt++;
    total_cnt++; if (if_id_instr !== 16'h0000) $display("FAIL reset_instr got %h exp 0000", if_id_instr); else pass_cnt++;
    total_cnt++; if (if_id_pc_plus2 !== 16'h0000) $display("FAIL reset_pcp2 got %h exp 0000", if_id_pc_plus2); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted got %h exp 0", halted); else pass_cnt++;
    total_cnt++; if (imem_addr !== 16'h0000) $display("FAIL reset_imem_addr got %h exp 0000", imem_addr); else pass_cnt++;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_free_run();
    logic [15:0] exp_next [3];
    exp_next[0] = 16'h0002; exp_next[1] = 16'h0004; exp_next[2] = 16'h0006;
    imem_rdata = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      pc = 16'(2 * i);
      #1;
      total_cnt++; if (pc_next !== exp_next[i]) $display("FAIL free_pc_next[%0d] got %h exp %h", i, pc_next, exp_next[i]); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL free_valid_before got %h exp 0", if_id_valid); else pass_cnt++;
      end
      tick();
      total_cnt++; if (if_id_pc_plus2 !== exp_next[i]) $display("FAIL free_pcp2[%0d] got %h exp %h", i, if_id_pc_plus2, exp_next[i]); else pass_cnt++;
      total_cnt++; if (if_id_valid !== 1'b1) $display("FAIL free_valid[%0d] got %h exp 1", i, if_id_valid); else pass_cnt++;
      total_cnt++; if (if_id_instr !== 16'h1234) $display("FAIL free_instr[%0d] got %h exp 1234", i, if_id_instr); else pass_cnt++;
    end
  endtask

  task automatic test_branch();
    pc = 16'h0010; imem_rdata = 16'h7777; branch_taken = 1'b1; branch_target = 16'h0100;
    #1;
    total_cnt++; if (pc_next !== 16'h0100) $display("FAIL br_pc_next got %h exp 0100", pc_next); else pass_cnt++;
    tick();
    branch_taken = 1'b0;
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL br_valid got %h exp 0", if_id_valid); else pass_cnt++;
    total_cnt++; if (if_id_instr !== 16'h0000) $display("FAIL br_instr got %h exp 0000", if_id_instr); else pass_cnt++;
    total_cnt++; if (if_id_pc_plus2 !== 16'h0000) $display("FAIL br_pcp2 got %h exp 0000", if_id_pc_plus2); else pass_cnt++;
    pc = 16'h0100; imem_rdata = 16'h5555;
    #1;
    total_cnt++; if (pc_next !== 16'h0102) $display("FAIL br_target_next got %h exp 0102", pc_next); else pass_cnt++;
    tick();
    total_cnt++; if (if_id_instr !== 16'h5555) $display("FAIL br_target_instr got %h exp 5555", if_id_instr); else pass_cnt++;
    total_cnt++; if (if_id_pc_plus2 !== 16'h0102) $display("FAIL br_target_pcp2 got %h exp 0102", if_id_pc_plus2); else pass_cnt++;
  endtask

  task automatic test_branch_stall();
    pc = 16'h0102; imem_rdata = 16'h6666; branch_taken = 1'b1; stall = 1'b1; branch_target = 16'h0200;
    #1;
    total_cnt++; if (pc_next !== 16'h0200) $display("FAIL brst_pc_next got %h exp 0200", pc_next); else pass_cnt++;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL brst_valid got %h exp 0", if_id_valid); else pass_cnt++;
    total_cnt++; if (if_id_instr !== 16'h0000) $display("FAIL brst_instr got %h exp 0000", if_id_instr); else pass_cnt++;
  endtask

  task automatic test_stall();
    pc = 16'h0008; imem_rdata = 16'h1111;
    tick();
    stall = 1'b1; imem_rdata = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (pc_next !== 16'h0008) $display("FAIL stall_pc_next[%0d] got %h exp 0008", i, pc_next); else pass_cnt++;
      tick();
      total_cnt++; if (if_id_instr !== 16'h1111) $display("FAIL stall_instr[%0d] got %h exp 1111", i, if_id_instr); else pass_cnt++;
      total_cnt++; if (if_id_pc_plus2 !== 16'h000A) $display("FAIL stall_pcp2[%0d] got %h exp 000a", i, if_id_pc_plus2); else pass_cnt++;
      total_cnt++; if (if_id_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %h exp 1", i, if_id_valid); else pass_cnt++;
    end
    stall = 1'b0;
    #1;
    total_cnt++; if (pc_next !== 16'h000A) $display("FAIL stall_resume got %h exp 000a", pc_next); else pass_cnt++;
    tick();
    total_cnt++; if (if_id_instr !== 16'h2222) $display("FAIL stall_resume_instr got %h exp 2222", if_id_instr); else pass_cnt++;
  endtask

  task automatic test_halt_under_branch();
    pc = 16'h0030; imem_rdata = 16'hF000; branch_taken = 1'b1; branch_target = 16'h0040;
    #1;
    total_cnt++; if (pc_next !== 16'h0040) $display("FAIL hb_pc_next got %h exp 0040", pc_next); else pass_cnt++;
    tick();
    branch_taken = 1'b0;
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL hb_valid got %h exp 0", if_id_valid); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL hb_halted got %h exp 0", halted); else pass_cnt++;
    pc = 16'h0040; imem_rdata = 16'h1234;
    #1;
    total_cnt++; if (pc_next !== 16'h0042) $display("FAIL hb_still_run got %h exp 0042", pc_next); else pass_cnt++;
    tick();
    total_cnt++; if (if_id_valid !== 1'b1) $display("FAIL hb_next_valid got %h exp 1", if_id_valid); else pass_cnt++;
  endtask

  task automatic test_wrap();
    pc = 16'hFFFE; imem_rdata = 16'h4321;
    #1;
    total_cnt++; if (pc_next !== 16'h0000) $display("FAIL wrap_pc_next got %h exp 0000", pc_next); else pass_cnt++;
    tick();
    total_cnt++; if (if_id_pc_plus2 !== 16'h0000) $display("FAIL wrap_pcp2 got %h exp 0000", if_id_pc_plus2); else pass_cnt++;
    total_cnt++; if (if_id_valid !== 1'b1) $display("FAIL wrap_valid got %h exp 1", if_id_valid); else pass_cnt++;
  endtask

  task automatic test_halt();
    pc = 16'h0020; imem_rdata = 16'hF000;
    #1;
    total_cnt++; if (pc_next !== 16'h0020) $display("FAIL halt_fetch_next got %h exp 0020", pc_next); else pass_cnt++;
    tick();
    total_cnt++; if (if_id_instr !== 16'hF000) $display("FAIL halt_ifid got %h exp f000", if_id_instr); else pass_cnt++;
    total_cnt++; if (if_id_pc_plus2 !== 16'h0022) $display("FAIL halt_pcp2 got %h exp 0022", if_id_pc_plus2); else pass_cnt++;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0300;
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++; if (pc_next !== 16'h0020) $display("FAIL hp_pc_next[%0d] got %h exp 0020", i, pc_next); else pass_cnt++;
      tick();
      total_cnt++; if (if_id_instr !== 16'hF000) $display("FAIL hp_instr[%0d] got %h exp f000", i, if_id_instr); else pass_cnt++;
      total_cnt++; if (if_id_valid !== 1'b1) $display("FAIL hp_valid[%0d] got %h exp 1", i, if_id_valid); else pass_cnt++;
      total_cnt++; if (halted !== 1'b0) $display("FAIL hp_halted[%0d] got %h exp 0", i, halted); else pass_cnt++;
    end
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    total_cnt++; if (halted !== 1'b1) $display("FAIL halted_set got %h exp 1", halted); else pass_cnt++;
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL halted_valid got %h exp 0", if_id_valid); else pass_cnt++;
    total_cnt++; if (if_id_instr !== 16'h0000) $display("FAIL halted_instr got %h exp 0000", if_id_instr); else pass_cnt++;
    branch_taken = 1'b1; branch_target = 16'h0400; imem_rdata = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++; if (pc_next !== 16'h0020) $display("FAIL halted_pc_next[%0d] got %h exp 0020", i, pc_next); else pass_cnt++;
      tick();
      total_cnt++; if (halted !== 1'b1) $display("FAIL halted_sticky[%0d] got %h exp 1", i, halted); else pass_cnt++;
      total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL halted_bubble[%0d] got %h exp 0", i, if_id_valid); else pass_cnt++;
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (halted !== 1'b0) $display("FAIL areset_halted got %h exp 0", halted); else pass_cnt++;
    total_cnt++; if (if_id_valid !== 1'b0) $display("FAIL areset_valid got %h exp 0", if_id_valid); else pass_cnt++;
    #1;
    rst_n = 1'b1;
    pc = 16'h0020; imem_rdata = 16'h1234;
    #1;
    total_cnt++; if (pc_next !== 16'h0022) $display("FAIL areset_run got %h exp 0022", pc_next); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_branch();
    test_branch_stall();
    test_stall();
    test_halt_under_branch();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage sitting directly around the program-counter register: it consumes the current `pc`, drives the instruction-memory address, computes `pc_next` for the PC register, and captures the fetched instruction into the IF/ID pipeline register. It implements sequential PC increment, taken-branch redirect with IF/ID flush, stall hold, and a three-state halt sequencer that freezes fetch once a HLT instruction has been fetched.

## Interface

- `RESET_PC`, default 16'h0000: value `pc` holds out of reset; reported in `if_id_pc_plus2` math only via `pc`.
- `HALT_OPCODE`, default 4'hF: opcode in `imem_rdata[15:12]` that identifies HLT.
- `NOP_INSTR`, default 16'h0000: instruction value loaded into IF/ID for a bubble.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pc`  in  16  current PC from the PC register.
- `pc_next`  out  16  next PC to the PC register; combinational.
- `imem_addr`  out  16  instruction-memory address; equals `pc`; combinational.
- `imem_rdata`  in  16  instruction word at `imem_addr`, valid in the same cycle.
- `stall`  in  1  hazard stall from decode; holds PC and IF/ID.
- `branch_taken`  in  1  taken branch resolved in decode this cycle.
- `branch_target`  in  16  redirect address; qualified by `branch_taken`.
- `if_id_instr`  out  16  registered instruction for decode.
- `if_id_pc_plus2`  out  16  registered PC+2 of that instruction.
- `if_id_valid`  out  1  registered; 1 = `if_id_instr` is a real instruction.
- `halted`  out  1  registered; 1 once the halt sequence has completed.

## Operation

- `pc_plus2 = pc + 16'd2`, modulo 2^16 (16'hFFFE + 2 = 16'h0000, no carry out).
- `is_halt = (imem_rdata[15:12] == HALT_OPCODE)`.
- States: RUN, HALT_PEND, HALTED. Reset state RUN.
- RUN, evaluated in priority order:
  - `branch_taken`: `pc_next = branch_target`; IF/ID loads bubble (`NOP_INSTR`, valid 0, pc_plus2 0); stay RUN. Wins over `stall` and over `is_halt` (the fetched word is squashed).
  - `stall`: `pc_next = pc`; IF/ID holds all fields; stay RUN.
  - `is_halt`: `pc_next = pc`; IF/ID loads `imem_rdata`, `pc_plus2`, valid 1; go HALT_PEND.
  - otherwise: `pc_next = pc_plus2`; IF/ID loads `imem_rdata`, `pc_plus2`, valid 1.
- HALT_PEND (HLT sits in IF/ID): `pc_next = pc`; `branch_taken` ignored.
  - `stall`: IF/ID holds; stay HALT_PEND.
  - no `stall`: IF/ID loads bubble; go HALTED.
- HALTED: `pc_next = pc`; IF/ID holds bubble; `branch_taken`/`stall` ignored; absorbing until reset.
- `halted = 1` exactly while in HALTED.

## Timing

- Reset (asynchronous, any state, including mid-halt): state RUN, `if_id_instr = NOP_INSTR`, `if_id_pc_plus2 = 0`, `if_id_valid = 0`, `halted = 0`. Combinational outputs follow `pc`.
- Fetch latency: word at `pc` in cycle N appears on `if_id_instr` after edge N+1.
- Redirect: `branch_taken` in cycle N means `pc = branch_target` after edge N+1, with a bubble in IF/ID the same edge. The target instruction is valid in IF/ID after edge N+2. Penalty is one bubble.
- Stall: every registered output and the effective PC are unchanged across the edge. There is no limit on stall length.
- Halt: HLT fetched at cycle N means IF/ID holds HLT after edge N+1. After the first unstalled edge following that, `if_id_valid = 0` and `halted = 1`. The PC never advances past the HLT address.
- Simultaneous `branch_taken` + `stall` in RUN: redirect and flush, with the stall ignored.

## Test plan

- Reset then free-run, `imem_rdata` = 16'h1234 each cycle: `pc_next` sequence 0002, 0004, 0006; `if_id_pc_plus2` lags by one cycle; `if_id_valid` 0 then 1.
- `pc` = 16'h0010 and `branch_taken`=1 with `branch_target`=16'h0100: `pc_next`=16'h0100; next cycle `if_id_valid`=0, `if_id_instr`=16'h0000.
- `stall` held 3 cycles at `pc`=16'h0008: `pc_next`=16'h0008 throughout; IF/ID unchanged; resumes with 16'h000A.
- HLT (16'hF000) fetched at 16'h0020 with `stall` asserted 2 cycles in HALT_PEND: IF/ID holds F000 for those cycles, then `halted`=1 and `if_id_valid`=0. `pc_next` stays 16'h0020 forever, and a later `branch_taken` has no effect.
- HLT fetched in the same cycle as `branch_taken` to 16'h0040: no halt; `pc_next`=16'h0040, state RUN, bubble in IF/ID.
- `pc`=16'hFFFE free-run gives `pc_next`=16'h0000. Asserting `rst_n`=0 asynchronously while HALTED gives `halted`=0 and `if_id_valid`=0 immediately, without waiting for a clock edge.
